// File: rtl/rvv_push_packer_pkg.sv
// Shared lane-compaction helpers: mask popcount, per-lane output rank and FIFO space decode.
// Functions work on a mask widened to MAX_LANES so any legal lane count can reuse them.
package rvv_push_packer_pkg;

    localparam int MAX_LANES  = 8;
    localparam int LANE_CNT_W = 4;

    function automatic logic [LANE_CNT_W-1:0] lane_popcount(input logic [MAX_LANES-1:0] mask);
        logic [LANE_CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            c = c + {{(LANE_CNT_W-1){1'b0}}, mask[i]};
        end
        return c;
    endfunction

    // Prefix sum of the mask below 'lane': the slot a valid lane lands in after compaction.
    function automatic logic [LANE_CNT_W-1:0] lane_rank(input logic [MAX_LANES-1:0] mask,
                                                       input int lane);
        logic [LANE_CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i < lane) begin
                c = c + {{(LANE_CNT_W-1){1'b0}}, mask[i]};
            end
        end
        return c;
    endfunction

    function automatic logic [1:0] fifo_space(input logic full, input logic one_left);
        logic [1:0] s;
        if (full) begin
            s = 2'd0;
        end else if (one_left) begin
            s = 2'd1;
        end else begin
            s = 2'd2;
        end
        return s;
    endfunction

endpackage

// File: rtl/rvv_push_packer_if.sv
// Lane-group input handshake plus the dual-push write port of the downstream 2W/2R FIFO.
interface rvv_push_packer_if #(
    parameter int DWIDTH = 32,
    parameter int LANES  = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES-1:0]          in_mask;
    logic [LANES*DWIDTH-1:0]   in_data;
    logic                      push0;
    logic [DWIDTH-1:0]         inData0;
    logic                      push1;
    logic [DWIDTH-1:0]         inData1;
    logic                      fifo_full;
    logic                      fifo_1left_to_full;

    modport master (
        input  in_valid, in_mask, in_data, fifo_full, fifo_1left_to_full,
        output in_ready, push0, inData0, push1, inData1
    );

    modport slave (
        output in_valid, in_mask, in_data, fifo_full, fifo_1left_to_full,
        input  in_ready, push0, inData0, push1, inData1
    );
endinterface

// File: rtl/rvv_push_packer_lane_compactor.sv
// Combinational lane compactor: valid lanes moved to the low slots in ascending lane order.
module rvv_lane_compactor
    import rvv_push_packer_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int LANES  = 4,
    parameter int CNTW   = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0]        mask,
    input  logic [LANES*DWIDTH-1:0] data,
    output logic [LANES*DWIDTH-1:0] packed_data,
    output logic [CNTW-1:0]         count
);

    logic [MAX_LANES-1:0] mask_ext;

    always_comb begin
        mask_ext              = '0;
        mask_ext[LANES-1:0]   = mask;
        packed_data           = '0;
        for (int j = 0; j < LANES; j++) begin
            for (int i = 0; i < LANES; i++) begin
                if (mask[i] && (lane_rank(mask_ext, i) == LANE_CNT_W'(j))) begin
                    packed_data[j*DWIDTH +: DWIDTH] = data[i*DWIDTH +: DWIDTH];
                end
            end
        end
        count = CNTW'(lane_popcount(mask_ext));
    end

endmodule

// File: rtl/rvv_push_packer.sv
// Packs masked lane groups and drains them as up to two in-order FIFO writes per cycle.
// A new group is taken in the same cycle the last residue element leaves.
module rvv_push_packer
    import rvv_push_packer_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int LANES  = 4,
    parameter int CNTW   = $clog2(LANES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    rvv_push_packer_if.master  bus,
    output logic               busy
);

    logic [DWIDTH-1:0]         data_q [LANES];
    logic [DWIDTH-1:0]         data_d [LANES];
    logic [CNTW-1:0]           cnt_q, cnt_d;
    logic [CNTW-1:0]           rd_q, rd_d;
    logic [CNTW-1:0]           rd_p1;
    logic [CNTW-1:0]           n_w;
    logic [1:0]                space;
    logic [1:0]                n;
    logic                      accept;
    logic                      ready;
    logic [DWIDTH-1:0]         out0, out1;
    logic [LANES*DWIDTH-1:0]   packed_data;
    logic [CNTW-1:0]           packed_cnt;

    rvv_lane_compactor #(
        .DWIDTH (DWIDTH),
        .LANES  (LANES),
        .CNTW   (CNTW)
    ) u_compactor (
        .mask        (bus.in_mask),
        .data        (bus.in_data),
        .packed_data (packed_data),
        .count       (packed_cnt)
    );

    // Drain count is held at zero during reset so the discarded residue never reaches the FIFO.
    always_comb begin
        space = fifo_space(bus.fifo_full, bus.fifo_1left_to_full);
        n     = 2'd2;
        if (space < n) begin
            n = space;
        end
        if (cnt_q < CNTW'(n)) begin
            n = cnt_q[1:0];
        end
        if (rst) begin
            n = 2'd0;
        end
        n_w    = CNTW'(n);
        ready  = (cnt_q == n_w);
        accept = bus.in_valid && ready;
        rd_p1  = rd_q + CNTW'(1);

        out0 = '0;
        out1 = '0;
        for (int i = 0; i < LANES; i++) begin
            if (CNTW'(i) == rd_q) begin
                out0 = data_q[i];
            end
            if (CNTW'(i) == rd_p1) begin
                out1 = data_q[i];
            end
        end

        cnt_d  = cnt_q - n_w;
        rd_d   = rd_q + n_w;
        data_d = data_q;
        if (accept) begin
            cnt_d = packed_cnt;
            rd_d  = '0;
            for (int i = 0; i < LANES; i++) begin
                data_d[i] = packed_data[i*DWIDTH +: DWIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            rd_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            rd_q  <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign bus.push0    = (n != 2'd0);
    assign bus.push1    = (n == 2'd2);
    assign bus.inData0  = out0;
    assign bus.inData1  = out1;
    assign bus.in_ready = ready;
    assign busy         = (cnt_q != '0);

`ifdef ASSERT_ON
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!bus.push1 || bus.push0);
            assert (cnt_q <= CNTW'(LANES));
            assert (!accept || (cnt_q == n_w));
        end
    end
`endif

endmodule

// File: tb/tb_rvv_push_packer.sv
// Bench for rvv_push_packer: directed table rows, then random traffic against a queue model.
module tb_rvv_push_packer;

    localparam int DW = 32;
    localparam int LN = 4;

    typedef struct {
        bit       rst;
        bit       valid;
        bit [3:0] mask;
        bit       full;
        bit       oneleft;
        bit       p0;
        bit       p1;
        bit       rdy;
        bit       busy;
    } vec_t;

    logic clk;
    logic rst;
    logic busy;

    int   n_vec;
    int   n_err;
    int   group_id;
    bit   hold;
    logic [DW-1:0] model_q[$];
    vec_t tbl[24];

    rvv_push_packer_if #(.DWIDTH(DW), .LANES(LN)) bus ();

    rvv_push_packer #(.DWIDTH(DW), .LANES(LN)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input string sig, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s.%s got=%h want=%h", tag, sig, act, exp);
        end
    endtask

    // Upstream holds mask/data while a presented group is not yet accepted.
    task automatic applyStimulus(input bit r, input bit v, input bit [3:0] m,
                                 input bit f, input bit o);
        rst                    = r;
        bus.fifo_full          = f;
        bus.fifo_1left_to_full = o;
        if (!hold) begin
            bus.in_valid = v;
            bus.in_mask  = m;
            group_id++;
            for (int i = 0; i < LN; i++) begin
                bus.in_data[i*DW +: DW] = 32'hA000_0000 | (group_id << 8) | i;
            end
        end
    endtask

    // Model: a FIFO of pending elements; up to min(pending, space, 2) leave per cycle.
    task automatic checkOutput(input string tag, input bit use_tbl, input vec_t e);
        int sp;
        int n;
        bit ep0, ep1, erdy, ebusy;
        @(negedge clk);
        sp = bus.fifo_full ? 0 : (bus.fifo_1left_to_full ? 1 : 2);
        n  = model_q.size();
        if (sp < n) n = sp;
        if (n > 2) n = 2;
        if (rst) n = 0;
        ep0   = (n >= 1);
        ep1   = (n == 2);
        erdy  = (model_q.size() == n);
        ebusy = (model_q.size() != 0);
        cmp(tag, "push0", 32'(bus.push0), 32'(ep0));
        cmp(tag, "push1", 32'(bus.push1), 32'(ep1));
        cmp(tag, "in_ready", 32'(bus.in_ready), 32'(erdy));
        cmp(tag, "busy", 32'(busy), 32'(ebusy));
        if (ep0) cmp(tag, "inData0", bus.inData0, model_q[0]);
        if (ep1) cmp(tag, "inData1", bus.inData1, model_q[1]);
        if (use_tbl) begin
            cmp(tag, "tbl_push0", 32'(bus.push0), 32'(e.p0));
            cmp(tag, "tbl_push1", 32'(bus.push1), 32'(e.p1));
            cmp(tag, "tbl_ready", 32'(bus.in_ready), 32'(e.rdy));
            cmp(tag, "tbl_busy", 32'(busy), 32'(e.busy));
        end
        if (rst) begin
            model_q.delete();
        end else begin
            repeat (n) void'(model_q.pop_front());
            if (bus.in_valid && erdy) begin
                for (int i = 0; i < LN; i++) begin
                    if (bus.in_mask[i]) model_q.push_back(bus.in_data[i*DW +: DW]);
                end
            end
        end
        hold = bus.in_valid && !erdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t none;
        none     = '{0, 0, 4'h0, 0, 0, 0, 0, 0, 0};
        n_vec    = 0;
        n_err    = 0;
        group_id = 0;
        hold     = 0;

        //            rst v  mask    f  o  p0 p1 rdy busy
        tbl[0]  = '{1, 1, 4'hF,   0, 0, 0, 0, 1, 0};
        tbl[1]  = '{1, 1, 4'hF,   0, 0, 0, 0, 1, 0};
        tbl[2]  = '{0, 1, 4'hF,   0, 0, 0, 0, 1, 0};
        tbl[3]  = '{0, 0, 4'h0,   0, 1, 1, 0, 0, 1};
        tbl[4]  = '{0, 1, 4'b1010, 0, 1, 1, 0, 0, 1};
        tbl[5]  = '{0, 1, 4'b1010, 0, 0, 1, 1, 1, 1};
        tbl[6]  = '{0, 0, 4'h0,   0, 0, 1, 1, 1, 1};
        tbl[7]  = '{0, 1, 4'b1011, 0, 0, 0, 0, 1, 0};
        tbl[8]  = '{0, 0, 4'h0,   1, 0, 0, 0, 0, 1};
        tbl[9]  = '{0, 0, 4'h0,   1, 1, 0, 0, 0, 1};
        tbl[10] = '{0, 0, 4'h0,   1, 0, 0, 0, 0, 1};
        tbl[11] = '{0, 0, 4'h0,   1, 0, 0, 0, 0, 1};
        tbl[12] = '{0, 0, 4'h0,   1, 0, 0, 0, 0, 1};
        tbl[13] = '{0, 0, 4'h0,   0, 0, 1, 1, 0, 1};
        tbl[14] = '{0, 1, 4'h0,   0, 0, 1, 0, 1, 1};
        tbl[15] = '{0, 1, 4'b0001, 0, 0, 0, 0, 1, 0};
        tbl[16] = '{0, 1, 4'b0011, 0, 0, 1, 0, 1, 1};
        tbl[17] = '{0, 0, 4'h0,   0, 0, 1, 1, 1, 1};
        tbl[18] = '{0, 1, 4'hF,   0, 0, 0, 0, 1, 0};
        tbl[19] = '{0, 0, 4'h0,   0, 0, 1, 1, 0, 1};
        tbl[20] = '{1, 0, 4'h0,   0, 0, 0, 0, 0, 1};
        tbl[21] = '{0, 1, 4'b0110, 0, 0, 0, 0, 1, 0};
        tbl[22] = '{0, 0, 4'h0,   0, 0, 1, 1, 1, 1};
        tbl[23] = '{0, 0, 4'h0,   0, 0, 0, 0, 1, 0};

        applyStimulus(1, 1, 4'hF, 0, 0);
        @(posedge clk);
        #1;

        for (int r = 0; r < 24; r++) begin
            applyStimulus(tbl[r].rst, tbl[r].valid, tbl[r].mask, tbl[r].full, tbl[r].oneleft);
            checkOutput($sformatf("row%0d", r), 1, tbl[r]);
        end

        for (int c = 0; c < 400; c++) begin
            applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 7),
                          4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 3) == 0));
            checkOutput($sformatf("rnd%0d", c), 0, none);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
